l1_mem_arbiter: RTL and testbench
=================================

Name: l1_mem_arbiter

Overview:
Shares one memory-side request channel between the L1 instruction cache and the L1 data cache. Sequences block-refill reads as bursts and single-beat write-through stores. Grants one requester at a time and holds the grant until that transaction completes. Sits between the two L1 caches and a single AXI master adapter in the CPU wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
BLK_WORDS, 4, words per cache block refill (power of two, 2..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache request (read only)
i_addr  in  ADDR_W  I-cache block address
i_rdata  out  DATA_W  refill word to I-cache
i_rvalid  out  1  i_rdata valid this cycle
i_done  out  1  one-cycle pulse: I transaction complete
d_req  in  1  D-cache request
d_write  in  1  1 = single-word write, 0 = block read
d_addr  in  ADDR_W  D-cache address
d_wdata  in  DATA_W  write data
d_wstrb  in  DATA_W/8  byte strobes
d_rdata  out  DATA_W  refill word to D-cache
d_rvalid  out  1  d_rdata valid
d_done  out  1  one-cycle pulse: D transaction complete
m_req  out  1  request to memory adapter
m_write  out  1  write request
m_addr  out  ADDR_W  request address
m_len  out  4  beats minus one
m_wdata  out  DATA_W  write data
m_wstrb  out  DATA_W/8  strobes
m_ack  in  1  adapter accepted request
m_rvalid  in  1  read beat valid
m_rdata  in  DATA_W  read beat
m_rlast  in  1  final read beat
m_bdone  in  1  write response received

Behaviour:
- Reset: state IDLE, all outputs 0, rr_last = I (so D wins the first tie).
- Requesters keep req asserted and inputs stable until their done pulse; the arbiter registers request fields when it grants.
- IDLE: if only one req is high, grant it. If both are high, grant the side not served last (round-robin). On grant, latch owner and fields, then go to ISSUE the next cycle.
- ISSUE: m_req = 1 with registered fields.
  - Read: m_addr = latched address with the low log2(BLK_WORDS)+2 bits cleared; m_len = BLK_WORDS-1; m_write = 0.
  - Write: m_addr = d_addr unmodified; m_len = 0; m_write = 1; m_wdata and m_wstrb are the latched values.
  - On m_ack, drop m_req the same edge. Go to RDATA (read) or WRESP (write).
- RDATA: each m_rvalid forwards m_rdata combinationally to the owner's rdata with rvalid = 1, and increments a beat counter.
  - On m_rvalid & m_rlast: owner done pulses that cycle, update rr_last, go to IDLE.
  - If m_rlast arrives while beat counter != BLK_WORDS-1, still complete and set sticky err_len (internal, visible to the bench).
  - Beats with m_rvalid = 0 are ignored.
- WRESP: on m_bdone, d_done pulses, rr_last = D, go to IDLE.
- Non-owner rvalid/done are always 0. A request arriving mid-transaction waits; no preemption.
- Back-to-back: a new grant can occur the cycle after done (IDLE lasts 1 cycle minimum). Latency from req to m_req is 2 cycles.
- m_ack and m_rvalid are ignored outside ISSUE and RDATA respectively. m_bdone is ignored outside WRESP.
- i_write does not exist: the I side is always a block read.
- Reset mid-transaction returns to IDLE at the next edge. The in-flight transaction is abandoned without a done pulse.

Optional Feature:
ARB_DPRIO_EN. When defined, D always wins simultaneous requests and rr_last is unused. When undefined, simultaneous requests use round-robin as above. Single-request behaviour is identical in both cases.

Test Plan:
- Reset, then i_req=1, i_addr=0x0000_1234, BLK_WORDS=4 -> m_req at cycle 2, m_addr=0x0000_1230, m_len=3. 4 beats 0xA0..0xA3 appear on i_rdata, and i_done pulses on the 4th beat.
- d_req=1, d_write=1, d_addr=0x0001_0008, d_wstrb=0x3 -> m_write=1, m_len=0, m_addr=0x0001_0008. d_done pulses in the cycle m_bdone=1.
- Both reqs high continuously after reset -> grants alternate D, I, D, I. With ARB_DPRIO_EN defined, D is granted every time.
- i_req rises during a D read burst -> the I grant starts only after d_done. No i_rvalid is seen during the D beats.
- Insert m_rvalid=0 bubbles between beats and assert m_rlast on beat 2 of 4 -> transaction completes and err_len=1.
- Assert rst during RDATA -> next cycle state is IDLE, all outputs 0, and no done pulse is produced.

Source files
------------

// File: rtl/l1_mem_arbiter_if.sv
// Memory-side request channel shared by the L1 caches through l1_mem_arbiter.
// The master modport is the arbiter's view; the slave modport is the adapter's view.
interface l1_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m_req;
    logic                  m_write;
    logic [ADDR_W-1:0]     m_addr;
    logic [3:0]            m_len;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_ack;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_rlast;
    logic                  m_bdone;

    modport master (
        output m_req, m_write, m_addr, m_len, m_wdata, m_wstrb,
        input  m_ack, m_rvalid, m_rdata, m_rlast, m_bdone
    );

    modport slave (
        input  m_req, m_write, m_addr, m_len, m_wdata, m_wstrb,
        output m_ack, m_rvalid, m_rdata, m_rlast, m_bdone
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Arbitrates I-cache block refills and D-cache refills/write-through stores onto one memory channel.
// Define ARB_DPRIO_EN to give the D side fixed priority on simultaneous requests (default: round-robin).
module l1_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BLK_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rvalid,
    output logic                i_done,
    input  logic                d_req,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rvalid,
    output logic                d_done,
    l1_mem_arbiter_if.master    mem
);
    localparam int              OFS_W     = $clog2(BLK_WORDS) + 2;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << OFS_W) - ADDR_W'(1));
    localparam logic [3:0]      LAST_BEAT = 4'(BLK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_WRESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    state_t              state, state_nx;
    owner_t              owner, owner_nx;
    owner_t              rr_last, rr_last_nx;
    owner_t              tie_winner;
    logic                grant;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [3:0]          beat_cnt;
    logic                err_len;
    logic                beat_end;

`ifdef ARB_DPRIO_EN
    assign tie_winner = OWN_D;
`else
    assign tie_winner = (rr_last == OWN_I) ? OWN_D : OWN_I;
`endif

    assign beat_end = (state == S_RDATA) && mem.m_rvalid && mem.m_rlast;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nx   = state;
        owner_nx   = owner;
        rr_last_nx = rr_last;
        grant      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    grant    = 1'b1;
                    state_nx = S_ISSUE;
                    if (i_req && d_req) owner_nx = tie_winner;
                    else                owner_nx = d_req ? OWN_D : OWN_I;
                end
            end
            S_ISSUE: begin
                if (mem.m_ack) state_nx = write_q ? S_WRESP : S_RDATA;
            end
            S_RDATA: begin
                if (beat_end) begin
                    state_nx   = S_IDLE;
                    rr_last_nx = owner;
                end
            end
            S_WRESP: begin
                if (mem.m_bdone) begin
                    state_nx   = S_IDLE;
                    rr_last_nx = OWN_D;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= OWN_I;
            rr_last  <= OWN_I;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            beat_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            rr_last <= rr_last_nx;
            if (grant) begin
                addr_q   <= (owner_nx == OWN_D) ? d_addr : i_addr;
                write_q  <= (owner_nx == OWN_D) && d_write;
                wdata_q  <= d_wdata;
                wstrb_q  <= d_wstrb;
                beat_cnt <= '0;
            end
            if ((state == S_RDATA) && mem.m_rvalid) begin
                beat_cnt <= beat_cnt + 4'd1;
                if (mem.m_rlast && (beat_cnt != LAST_BEAT)) err_len <= 1'b1;
            end
        end
    end

    // Request fields are gated by state so the channel reads all-zero whenever it is idle.
    assign mem.m_req   = (state == S_ISSUE);
    assign mem.m_write = (state == S_ISSUE) && write_q;
    assign mem.m_addr  = (state != S_ISSUE) ? '0 : (write_q ? addr_q : (addr_q & BLK_MASK));
    assign mem.m_len   = ((state == S_ISSUE) && !write_q) ? LAST_BEAT : 4'd0;
    assign mem.m_wdata = mem.m_write ? wdata_q : '0;
    assign mem.m_wstrb = mem.m_write ? wstrb_q : '0;

    assign i_rvalid = (state == S_RDATA) && (owner == OWN_I) && mem.m_rvalid;
    assign d_rvalid = (state == S_RDATA) && (owner == OWN_D) && mem.m_rvalid;
    assign i_rdata  = i_rvalid ? mem.m_rdata : '0;
    assign d_rdata  = d_rvalid ? mem.m_rdata : '0;
    assign i_done   = beat_end && (owner == OWN_I);
    assign d_done   = (beat_end && (owner == OWN_D)) || ((state == S_WRESP) && mem.m_bdone);
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: expected requests and refill beats are queued when stimulus
// is driven and compared when the DUT presents them.
module tb_l1_mem_arbiter;
    localparam int ADDR_W = 32, DATA_W = 32, BLK_WORDS = 4;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rvalid, i_done;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_write, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        all_out_or;

    always #5 clk = ~clk;

    l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    l1_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem(bus.master)
    );

    assign all_out_or = |{i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_done, bus.m_req,
                          bus.m_write, bus.m_addr, bus.m_len, bus.m_wdata, bus.m_wstrb};

    int    n_checks = 0, n_fail = 0;
    int    i_done_cnt = 0, d_done_cnt = 0, exp_i_done = 0, exp_d_done = 0;
    req_t  exp_req[$];
    beat_t exp_i[$], exp_d[$];
    req_t  mon_r;
    beat_t mon_b;
    logic  prev_mreq = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares each new memory request and every forwarded refill beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_req && !prev_mreq) begin
                if (exp_req.size() == 0) check("mreq_spurious", bus.m_req, 0);
                else begin
                    mon_r = exp_req.pop_front();
                    check("m_write", bus.m_write, mon_r.write);
                    check("m_addr", bus.m_addr, mon_r.addr);
                    check("m_len", bus.m_len, mon_r.len);
                    if (mon_r.write) begin
                        check("m_wdata", bus.m_wdata, mon_r.wdata);
                        check("m_wstrb", bus.m_wstrb, mon_r.wstrb);
                    end
                end
            end
            if (i_rvalid) begin
                if (exp_i.size() == 0) check("i_rvalid_spurious", i_rvalid, 0);
                else begin
                    mon_b = exp_i.pop_front();
                    check("i_rdata", i_rdata, mon_b.data);
                    check("i_done_on_last", i_done, mon_b.last);
                end
            end else check("i_done_idle", i_done, 0);
            if (d_rvalid) begin
                if (exp_d.size() == 0) check("d_rvalid_spurious", d_rvalid, 0);
                else begin
                    mon_b = exp_d.pop_front();
                    check("d_rdata", d_rdata, mon_b.data);
                    check("d_done_on_last", d_done, mon_b.last);
                end
            end
            if (i_done) i_done_cnt++;
            if (d_done) d_done_cnt++;
        end
        prev_mreq = bus.m_req;
    end

    task automatic expect_read(input bit side_d, input logic [31:0] addr, input int n,
                               input logic [31:0] base);
        req_t r;
        beat_t b;
        r.write = 1'b0; r.addr = addr; r.len = 4'(BLK_WORDS - 1); r.wdata = '0; r.wstrb = '0;
        exp_req.push_back(r);
        for (int k = 0; k < n; k++) begin
            b.data = base + 32'(k);
            b.last = (k == n - 1);
            if (side_d) exp_d.push_back(b);
            else        exp_i.push_back(b);
        end
    endtask

    task automatic wait_mreq(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.m_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("mreq_timeout", bus.m_req, 1);
    endtask

    task automatic ack();
        bus.m_ack = 1'b1;
        @(posedge clk); #1;
        bus.m_ack = 1'b0;
    endtask

    // Adapter model: accepts the request, then returns n beats, rlast on the final one.
    task automatic serve_read(input int n, input logic [31:0] base, input bit bubbles);
        bit ok;
        wait_mreq(ok);
        if (!ok) return;
        ack();
        for (int k = 0; k < n; k++) begin
            if (bubbles) begin
                bus.m_rvalid = 1'b0; bus.m_rlast = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
                @(posedge clk); #1;
            end
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = base + 32'(k);
            bus.m_rlast  = (k == n - 1);
            @(posedge clk); #1;
        end
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rdata = '0;
    endtask

    task automatic serve_write();
        bit ok;
        wait_mreq(ok);
        if (!ok) return;
        ack();
        @(negedge clk);
        check("d_done_before_bdone", d_done, 0);
        @(posedge clk); #1;
        bus.m_bdone = 1'b1;
        @(negedge clk);
        check("d_done_on_bdone", d_done, 1);
        @(posedge clk); #1;
        bus.m_bdone = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        req_t w;
        bit   side_d, ok;
        int   saved_i, saved_d;
        i_req = 0; i_addr = 0; d_req = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        bus.m_ack = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rlast = 0; bus.m_bdone = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_state_idle", dut.state, 0);
        check("reset_outputs_zero", all_out_or, 0);

        // Single I refill: m_req in the second cycle of the request, block-aligned address.
        @(posedge clk); #1;
        i_req = 1; i_addr = 32'h0000_1234;
        expect_read(0, 32'h0000_1230, 4, 32'hA0);
        @(negedge clk);
        check("t1_mreq_cycle1", bus.m_req, 0);
        @(negedge clk);
        check("t1_mreq_cycle2", bus.m_req, 1);
        serve_read(4, 32'hA0, 0);
        i_req = 0; exp_i_done++;

        // Single D write-through store.
        d_req = 1; d_write = 1; d_addr = 32'h0001_0008; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
        w.write = 1; w.addr = 32'h0001_0008; w.len = 0; w.wdata = 32'hDEAD_BEEF; w.wstrb = 4'h3;
        exp_req.push_back(w);
        serve_write();
        d_req = 0; d_write = 0; exp_d_done++;

        // Both requesting continuously after reset.
        do_reset();
        d_addr = 32'h0000_204C; i_addr = 32'h0000_3007;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_DPRIO_EN
            side_d = 1'b1;
`else
            side_d = (k % 2 == 0);
`endif
            if (side_d) expect_read(1, 32'h0000_2040, 4, 32'hD0 + 32'(k * 16));
            else        expect_read(0, 32'h0000_3000, 4, 32'hB0 + 32'(k * 16));
        end
        d_req = 1; i_req = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_DPRIO_EN
            side_d = 1'b1;
`else
            side_d = (k % 2 == 0);
`endif
            serve_read(4, (side_d ? 32'hD0 : 32'hB0) + 32'(k * 16), 0);
            if (side_d) exp_d_done++;
            else        exp_i_done++;
        end
        d_req = 0; i_req = 0;

        // I request arrives during a D burst and must wait for d_done.
        @(posedge clk); #1;
        d_req = 1; d_addr = 32'h0000_5010;
        expect_read(1, 32'h0000_5010, 4, 32'hC0);
        expect_read(0, 32'h0000_6000, 4, 32'hE0);
        fork
            serve_read(4, 32'hC0, 0);
            begin
                repeat (3) @(posedge clk);
                #2 i_req = 1; i_addr = 32'h0000_6004;
            end
        join
        d_req = 0; exp_d_done++;
        serve_read(4, 32'hE0, 0);
        i_req = 0; exp_i_done++;

        // Short burst with bubbles: rlast on beat 2 of 4.
        check("t5_err_len_before", dut.err_len, 0);
        i_req = 1; i_addr = 32'h0000_7000;
        expect_read(0, 32'h0000_7000, 2, 32'hF0);
        serve_read(2, 32'hF0, 1);
        i_req = 0; exp_i_done++;
        check("t5_err_len_set", dut.err_len, 1);

        // Reset while in RDATA abandons the transaction.
        d_req = 1; d_addr = 32'h0000_8008;
        expect_read(1, 32'h0000_8000, 1, 32'h11);
        exp_d[exp_d.size() - 1].last = 1'b0;
        wait_mreq(ok);
        if (ok) begin
            ack();
            bus.m_rvalid = 1; bus.m_rdata = 32'h11; bus.m_rlast = 0;
            @(posedge clk); #1;
            bus.m_rvalid = 0; bus.m_rdata = 0;
            check("t6_in_rdata", dut.state, 2);
        end
        saved_i = i_done_cnt; saved_d = d_done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_state_idle", dut.state, 0);
        check("t6_outputs_zero", all_out_or, 0);
        check("t6_no_i_done", i_done, 0);
        check("t6_no_d_done", d_done, 0);
        rst = 1'b0; d_req = 0;
        repeat (3) @(posedge clk);
        check("t6_done_count_i", i_done_cnt, saved_i);
        check("t6_done_count_d", d_done_cnt, saved_d);
        check("t6_idle_after", all_out_or, 0);

        check("exp_req_left", exp_req.size(), 0);
        check("exp_i_left", exp_i.size(), 0);
        check("exp_d_left", exp_d.size(), 0);
        check("i_done_count", i_done_cnt, exp_i_done);
        check("d_done_count", d_done_cnt, exp_d_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
